// File: rtl/serial_link_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : serial_link_pkg
// Brief    : Link-format constants and state encoding shared by Tx and Rx.
// Revision : 1.0
// ============================================================================
package serial_link_pkg;

    localparam int   FRAME_BITS  = 40;
    localparam logic START_LEVEL = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b0;
    localparam int   MIN_GAP     = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_GAP   = 2'd3
    } link_state_t;

endpackage
`default_nettype wire

// File: rtl/serial_tx_arbiter_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker; FIXED_PRIO_EN makes req[0]
//            an absolute-priority requester outside the rotation.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_vld,
    output logic          ptr_upd
);

    logic [N-1:0] w_req;

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    always_comb begin
        w_req     = req;
        grant_idx = '0;
        grant_vld = 1'b0;
        ptr_upd   = 1'b0;
`ifdef FIXED_PRIO_EN
        w_req[0]  = 1'b0;
`endif
        for (int k = 0; k < N; k++) begin
            if (!grant_vld && w_req[wrap_idx(ptr, k)]) begin
                grant_vld = 1'b1;
                grant_idx = wrap_idx(ptr, k);
            end
        end
`ifdef FIXED_PRIO_EN
        // Requester 0 overrides the rotation and leaves the pointer alone
        if (req[0]) begin
            grant_vld = 1'b1;
            grant_idx = '0;
        end else begin
            ptr_upd = grant_vld;
        end
`else
        ptr_upd = grant_vld;
`endif
        grant = grant_vld ? (N'(1) << grant_idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/serial_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : serial_tx_arbiter
// Brief    : Round-robin N-way frame arbiter and serializer for the link
//            (start bit, 40 bits MSB first, low gap). Option: FIXED_PRIO_EN.
// Revision : 1.0
// ============================================================================
module serial_tx_arbiter
    import serial_link_pkg::*;
#(
    parameter int N   = 4,
    parameter int GAP = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N-1:0]            req,
    input  logic [N*FRAME_BITS-1:0] data_in,
    output logic [N-1:0]            ack,
    output logic                    so,
    output logic                    busy,
    output logic [2:0]              grant_id
);

    localparam int             c_iw       = $clog2(N);
    localparam int             c_gw       = $clog2(GAP + 1);
    localparam logic [c_gw-1:0] c_gap_last = c_gw'(GAP - 1);
    localparam logic [5:0]     c_bit_last = 6'(FRAME_BITS - 1);

    link_state_t             r_state, w_state;
    logic [FRAME_BITS-1:0]   r_shreg, w_shreg;
    logic [5:0]              r_bit_cnt, w_bit_cnt;
    logic [c_gw-1:0]         r_gap_cnt, w_gap_cnt;
    logic [c_iw-1:0]         r_ptr, w_ptr;
    logic [N-1:0]            r_ack, w_ack;
    logic                    r_so, w_so;
    logic                    r_busy, w_busy;
    logic [2:0]              r_grant_id, w_grant_id;

    logic [N-1:0]            w_grant;
    logic [c_iw-1:0]         w_idx;
    logic                    w_grant_vld;
    logic                    w_ptr_upd;
    logic                    w_load;
    logic [FRAME_BITS-1:0]   w_frame;

    rr_arbiter #(
        .N  (N),
        .IW (c_iw)
    ) u_rr_arbiter (
        .req       (req),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_idx),
        .grant_vld (w_grant_vld),
        .ptr_upd   (w_ptr_upd)
    );

    assign w_frame = data_in[int'(w_idx)*FRAME_BITS +: FRAME_BITS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_ptr      <= '0;
            r_ack      <= '0;
            r_so       <= IDLE_LEVEL;
            r_busy     <= 1'b0;
            r_grant_id <= '0;
        end else begin
            r_state    <= w_state;
            r_shreg    <= w_shreg;
            r_bit_cnt  <= w_bit_cnt;
            r_gap_cnt  <= w_gap_cnt;
            r_ptr      <= w_ptr;
            r_ack      <= w_ack;
            r_so       <= w_so;
            r_busy     <= w_busy;
            r_grant_id <= w_grant_id;
        end
    end

    // so is registered from the current state, so the line trails state by one cycle
    always_comb begin
        w_state    = r_state;
        w_shreg    = r_shreg;
        w_bit_cnt  = r_bit_cnt;
        w_gap_cnt  = r_gap_cnt;
        w_ptr      = r_ptr;
        w_ack      = '0;
        w_so       = IDLE_LEVEL;
        w_busy     = r_busy;
        w_grant_id = r_grant_id;
        w_load     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_load = w_grant_vld;
            end
            ST_START: begin
                w_so      = START_LEVEL;
                w_state   = ST_DATA;
                w_bit_cnt = '0;
            end
            ST_DATA: begin
                w_so    = r_shreg[FRAME_BITS-1];
                w_shreg = {r_shreg[FRAME_BITS-2:0], 1'b0};
                if (r_bit_cnt == c_bit_last) begin
                    w_state   = ST_GAP;
                    w_gap_cnt = '0;
                end else begin
                    w_bit_cnt = r_bit_cnt + 6'd1;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == c_gap_last) begin
                    w_load = w_grant_vld;
                    if (!w_grant_vld) begin
                        w_busy  = 1'b0;
                        w_state = ST_IDLE;
                    end
                end else begin
                    w_gap_cnt = r_gap_cnt + 1'b1;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        if (w_load) begin
            w_state    = ST_START;
            w_shreg    = w_frame;
            w_ack      = w_grant;
            w_grant_id = 3'(w_idx);
            w_busy     = 1'b1;
            if (w_ptr_upd) begin
                w_ptr = (w_idx == c_iw'(N - 1)) ? '0 : w_idx + 1'b1;
            end
        end
    end

    assign ack      = r_ack;
    assign so       = r_so;
    assign busy     = r_busy;
    assign grant_id = r_grant_id;

endmodule
`default_nettype wire
